// File: rtl/dragon_body_queue.sv
`default_nettype none
// ==========================================================================
// dragon_body_queue - frame-paced body segment shift queue | rev 1.0
// ==========================================================================
module dragon_body_queue #(
  parameter int SEG_W    = 10,
  parameter int MAX_LEN  = 8,
  parameter int INIT_LEN = 1,
  parameter int DIV_W    = 6
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       frame_tick,
  input  logic                       cmd_valid,
  input  logic [1:0]                 cmd,
  input  logic [SEG_W-1:0]           head_in,
  input  logic [DIV_W-1:0]           move_period,
  output logic [MAX_LEN*SEG_W-1:0]   segments,
  output logic [MAX_LEN-1:0]         seg_en,
  output logic [$clog2(MAX_LEN+1)-1:0] length,
  output logic                       step,
  output logic                       full,
  output logic                       dead,
  output logic                       overflow
);

  localparam int LEN_W = $clog2(MAX_LEN+1);

  localparam logic [0:0] ST_ALIVE = 1'b0;
  localparam logic [0:0] ST_DEAD  = 1'b1;

  localparam logic [1:0] CMD_HEAL = 2'b01;
  localparam logic [1:0] CMD_HIT  = 2'b10;

  localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] LEN_INIT = LEN_W'(INIT_LEN);

  logic [0:0]       state;
  logic [DIV_W-1:0] fcnt;
  logic [DIV_W-1:0] period_m1;
  logic             alive;
  logic             do_step;
  logic             accept;

  assign alive     = (state == ST_ALIVE);
  // A zero period behaves as one frame per step.
  assign period_m1 = (move_period == '0) ? '0 : move_period - DIV_W'(1);
  // ">=" rather than "==" so a shortened period steps on the next tick.
  assign do_step   = alive && frame_tick && (fcnt >= period_m1);
  assign accept    = alive && cmd_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fcnt     <= '0;
      segments <= '0;
      step     <= 1'b0;
    end else begin
      step <= do_step;
      if (do_step) begin
        fcnt     <= '0;
        segments <= {segments[(MAX_LEN-1)*SEG_W-1:0], head_in};
      end else if (alive && frame_tick) begin
        fcnt <= fcnt + DIV_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_ALIVE;
      length   <= LEN_INIT;
      overflow <= 1'b0;
    end else if (accept) begin
      if (cmd == CMD_HEAL) begin
        if (length == LEN_MAX) overflow <= 1'b1;
        else                   length   <= length + LEN_W'(1);
      end else if (cmd == CMD_HIT) begin
        length <= length - LEN_W'(1);
        if (length == LEN_W'(1)) state <= ST_DEAD;
      end
    end
  end

  for (genvar k = 0; k < MAX_LEN; k++) begin : g_seg_en
    assign seg_en[k] = (LEN_W'(k) < length);
  end

  assign full = (length == LEN_MAX);
  assign dead = (state == ST_DEAD);

endmodule
`default_nettype wire

// File: tb/tb_dragon_body_queue.sv
`default_nettype none
// ==========================================================================
// tb_dragon_body_queue - random + directed bench with queue-level model | rev 1.0
// ==========================================================================
module tb_dragon_body_queue;

  localparam int SEG_W    = 10;
  localparam int MAX_LEN  = 8;
  localparam int INIT_LEN = 1;
  localparam int DIV_W    = 6;
  localparam int LEN_W    = $clog2(MAX_LEN+1);

  logic                     clk = 1'b0;
  logic                     reset = 1'b0;
  logic                     frame_tick = 1'b0;
  logic                     cmd_valid = 1'b0;
  logic [1:0]               cmd = 2'b11;
  logic [SEG_W-1:0]         head_in = '0;
  logic [DIV_W-1:0]         move_period = '0;
  logic [MAX_LEN*SEG_W-1:0] segments;
  logic [MAX_LEN-1:0]       seg_en;
  logic [LEN_W-1:0]         length;
  logic                     step, full, dead, overflow;

  dragon_body_queue #(.SEG_W(SEG_W), .MAX_LEN(MAX_LEN), .INIT_LEN(INIT_LEN), .DIV_W(DIV_W)) dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .cmd_valid(cmd_valid),
    .cmd(cmd), .head_in(head_in), .move_period(move_period), .segments(segments),
    .seg_en(seg_en), .length(length), .step(step), .full(full), .dead(dead),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: list of body values, a length, a frames-since-step count.
  logic [SEG_W-1:0] m_seg [MAX_LEN];
  int               m_len;
  int               m_frames;
  bit               m_dead, m_ovf, m_step;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic model_reset();
    foreach (m_seg[k]) m_seg[k] = '0;
    m_len = INIT_LEN; m_frames = 0; m_dead = 0; m_ovf = 0; m_step = 0;
  endtask

  task automatic model_edge();
    int period;
    bit moved;
    moved = 0;
    if (!m_dead) begin
      period = (move_period == 0) ? 1 : int'(move_period);
      if (frame_tick) begin
        if (m_frames + 1 >= period) begin
          moved = 1;
          m_frames = 0;
          for (int k = MAX_LEN-1; k > 0; k--) m_seg[k] = m_seg[k-1];
          m_seg[0] = head_in;
        end else m_frames++;
      end
      if (cmd_valid && cmd == 2'b01) begin
        if (m_len == MAX_LEN) m_ovf = 1; else m_len++;
      end else if (cmd_valid && cmd == 2'b10) begin
        m_len--;
        if (m_len == 0) m_dead = 1;
      end
    end
    m_step = moved;
  endtask

  task automatic check_all(input string tag);
    logic [MAX_LEN*SEG_W-1:0] exp_seg;
    for (int k = 0; k < MAX_LEN; k++) exp_seg[k*SEG_W +: SEG_W] = m_seg[k];
    check({tag, ".segments"}, 128'(segments), 128'(exp_seg));
    check({tag, ".seg_en"},   128'(seg_en),   128'(((1 << m_len) - 1) & ((1 << MAX_LEN) - 1)));
    check({tag, ".length"},   128'(length),   128'(m_len));
    check({tag, ".step"},     128'(step),     128'(m_step));
    check({tag, ".full"},     128'(full),     128'(m_len == MAX_LEN));
    check({tag, ".dead"},     128'(dead),     128'(m_dead));
    check({tag, ".overflow"}, 128'(overflow), 128'(m_ovf));
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic set_idle();
    frame_tick = 0; cmd_valid = 0; cmd = 2'b11;
  endtask

  // Reset lands between clock edges; outputs must update before any edge.
  task automatic do_reset(input string tag);
    #2 reset = 1;
    #1 model_reset();
    check_all(tag);
    check({tag, ".async_len"}, 128'(length), 128'(INIT_LEN));
    @(posedge clk);
    #2 reset = 0;
  endtask

  initial begin
    logic [SEG_W-1:0] va, vb, vc, vx;
    logic [SEG_W-1:0] heads [3];

    model_reset();
    set_idle();
    do_reset("rst0");

    // Stepping every second frame with three distinct head values.
    va = 10'h1A5; vb = 10'h2C3; vc = 10'h07E;
    heads[0] = va; heads[1] = vb; heads[2] = vc;
    move_period = 2;
    for (int t = 1; t <= 6; t++) begin
      head_in = heads[(t-1)/2];
      frame_tick = 1; tick("p2_tick");
      check("p2_step", 128'(step), 128'(t % 2 == 0));
      frame_tick = 0; tick("p2_gap");
    end
    check("p2_slot0", 128'(segments[0*SEG_W +: SEG_W]), 128'(vc));
    check("p2_slot1", 128'(segments[1*SEG_W +: SEG_W]), 128'(vb));
    check("p2_slot2", 128'(segments[2*SEG_W +: SEG_W]), 128'(va));
    check("p2_seg_en", 128'(seg_en), 128'(8'b0000_0001));

    // Grow to full, overflow, then shrink.
    do_reset("rst1");
    cmd_valid = 1; cmd = 2'b01;
    for (int i = 0; i < 7; i++) tick("heal");
    check("full_len", 128'(length), 128'(8));
    check("full_flag", 128'(full), 128'(1));
    check("full_ovf0", 128'(overflow), 128'(0));
    tick("heal_over");
    check("ovf_set", 128'(overflow), 128'(1));
    check("full_seg_en", 128'(seg_en), 128'(8'hFF));
    cmd = 2'b10;
    for (int i = 0; i < 3; i++) tick("hit");
    check("hit_len", 128'(length), 128'(5));
    check("ovf_sticky", 128'(overflow), 128'(1));
    check("hit_full", 128'(full), 128'(0));
    set_idle();

    // Final HIT coincident with a step.
    do_reset("rst2");
    move_period = 1; vx = 10'h3B1; head_in = vx;
    frame_tick = 1; cmd_valid = 1; cmd = 2'b10;
    tick("kill");
    check("kill_slot0", 128'(segments), 128'(vx));
    check("kill_len", 128'(length), 128'(0));
    check("kill_seg_en", 128'(seg_en), 128'(0));
    check("kill_dead", 128'(dead), 128'(1));
    check("kill_step", 128'(step), 128'(1));
    cmd = 2'b01;
    for (int i = 0; i < 4; i++) begin
      head_in = 10'(i + 5);
      tick("dead_ign");
      check("dead_step", 128'(step), 128'(0));
      check("dead_frozen", 128'(segments), 128'(vx));
      check("dead_len", 128'(length), 128'(0));
    end
    set_idle();

    // Zero period steps every tick; shortening the period mid-count.
    do_reset("rst3");
    move_period = 0;
    for (int i = 0; i < 3; i++) begin
      head_in = 10'(i + 1);
      frame_tick = 1; tick("p0_tick");
      check("p0_step", 128'(step), 128'(1));
      frame_tick = 0; tick("p0_gap");
    end
    move_period = 5;
    for (int i = 0; i < 3; i++) begin
      frame_tick = 1; tick("p5_tick");
      check("p5_nostep", 128'(step), 128'(0));
    end
    move_period = 2;
    frame_tick = 1; tick("p2_short");
    check("short_step", 128'(step), 128'(1));
    set_idle();

    // Asynchronous reset from a live, length-6 state.
    do_reset("rst4");
    cmd_valid = 1; cmd = 2'b01;
    for (int i = 0; i < 5; i++) begin
      head_in = 10'($urandom);
      frame_tick = 1;
      tick("grow6");
    end
    set_idle();
    tick("pre_rst");
    check("pre_rst_len", 128'(length), 128'(6));
    check("pre_rst_dead", 128'(dead), 128'(0));
    do_reset("rst_mid");
    check("rst_mid_seg", 128'(segments), 128'(0));
    check("rst_mid_en", 128'(seg_en), 128'(8'b0000_0001));

    // Randomized episodes against the model.
    for (int ep = 0; ep < 8; ep++) begin
      do_reset("rst_rand");
      move_period = DIV_W'($urandom_range(0, 4));
      for (int c = 0; c < 300; c++) begin
        int r;
        frame_tick = ($urandom_range(0, 2) == 0);
        cmd_valid  = ($urandom_range(0, 3) == 0);
        r = $urandom_range(0, 9);
        cmd = (r < 5) ? 2'b01 : (r == 5) ? 2'b10 : (r < 8) ? 2'b00 : 2'b11;
        head_in = 10'($urandom);
        if ($urandom_range(0, 15) == 0) move_period = DIV_W'($urandom_range(0, 6));
        tick("rand");
      end
      set_idle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dragon_body_queue.md
DRAGON_BODY_QUEUE -- requirements
Module: dragon_body_queue

Interface
REQ-001 SHALL have parameter SEG_W, default 10, meaning bits per body segment ({orientation, position}).
REQ-002 SHALL have parameter MAX_LEN, default 8, meaning number of segment slots (2..32).
REQ-003 SHALL have parameter INIT_LEN, default 1, meaning displayed length after reset (1..MAX_LEN).
REQ-004 SHALL have parameter DIV_W, default 6, meaning width of the move-period input.
REQ-005 SHALL have port clk, input, 1, meaning the system clock; all logic is clocked on the rising edge.
REQ-006 SHALL have port reset, input, 1, meaning asynchronous, active-high reset.
REQ-007 SHALL have port frame_tick, input, 1, meaning a one-clk pulse per video frame, already synchronous to clk.
REQ-008 SHALL have port cmd_valid, input, 1, meaning cmd is sampled in this cycle.
REQ-009 SHALL have port cmd, input, 2, meaning 00 MOVE, 01 HEAL, 10 HIT, 11 IDLE.
REQ-010 SHALL have port head_in, input, SEG_W, meaning the new head segment value.
REQ-011 SHALL have port move_period, input, DIV_W, meaning the number of frames per body step.
REQ-012 SHALL have port segments, output, MAX_LEN*SEG_W, meaning the slot contents; slot k occupies bits [k*SEG_W +: SEG_W] and slot 0 is the head.
REQ-013 SHALL have port seg_en, output, MAX_LEN, meaning a thermometer display enable in which bit k=1 iff k < length.
REQ-014 SHALL have port length, output, $clog2(MAX_LEN+1), meaning the current segment count.
REQ-015 SHALL have port step, output, 1, meaning a one-clk pulse in the cycle in which the queue shifted.
REQ-016 SHALL have port full, output, 1, meaning length==MAX_LEN.
REQ-017 SHALL have port dead, output, 1, meaning the state is DEAD (level).
REQ-018 SHALL have port overflow, output, 1, meaning a sticky flag set by a HEAL received while full.

Function
REQ-019 SHALL implement states ALIVE and DEAD; reset enters ALIVE; ALIVE->DEAD when a HIT is accepted at length==1; DEAD is left only by reset.
REQ-020 SHALL hold a frame counter fcnt (DIV_W bits) that increments on frame_tick in ALIVE; when frame_tick arrives with fcnt >= eff_period-1, fcnt SHALL become 0 and a step SHALL occur in that same cycle.
REQ-021 SHALL use eff_period = move_period, except that move_period==0 SHALL be treated as 1 (step on every frame_tick).
REQ-022 SHALL, when move_period changes while fcnt >= the new eff_period-1, step on the next frame_tick; fcnt SHALL never wrap past the period.
REQ-023 SHALL, on step, move every slot k to slot k+1 for k = 0..MAX_LEN-2, load slot 0 with head_in, and discard slot MAX_LEN-1; all slots SHALL shift regardless of seg_en.
REQ-024 SHALL assert the step output for exactly the cycle after the shift (registered), one pulse per shift.
REQ-025 SHALL, when HEAL is accepted (cmd_valid=1, ALIVE), set length <= min(length+1, MAX_LEN); HEAL at full SHALL leave length unchanged and set overflow.
REQ-026 SHALL, when HIT is accepted, set length <= length-1; at length==1, length SHALL become 0, seg_en SHALL become all-zero, and the state SHALL go to DEAD.
REQ-027 SHALL treat MOVE and IDLE as no change to length; MOVE SHALL NOT force a step, since stepping is governed only by frame_tick and fcnt.
REQ-028 SHALL, when a step and a HEAL occur in the same cycle, apply both, so the newly exposed slot holds the value shifted in that cycle.
REQ-029 SHALL, when a step and a HIT occur in the same cycle, apply both; at length==1 the final shift SHALL still occur and the state SHALL then be DEAD.
REQ-030 SHALL, in DEAD, freeze segments, hold fcnt, produce no step pulses, and ignore all commands; dead SHALL stay 1 until reset.
REQ-031 SHALL derive seg_en, full, and dead combinationally from the registered length and state, with zero latency from the register update.
REQ-032 SHALL clear overflow only on reset.

Reset
REQ-033 SHALL, on asserted reset (asynchronous, any state), immediately set: all slots 0; length=INIT_LEN; seg_en=(1<<INIT_LEN)-1; fcnt=0; step=0; overflow=0; state ALIVE (dead=0); full=(INIT_LEN==MAX_LEN).
REQ-034 SHALL, on reset deasserted mid-frame, make the first step occur on the eff_period-th subsequent frame_tick.

Verification
REQ-035 SHALL verify: defaults, move_period=2, head_in=A,B,C in turn over 6 frame_ticks -> steps on ticks 2, 4, 6; slot0=C, slot1=B, slot2=A; seg_en=8'b00000001.
REQ-036 SHALL verify: 7 HEALs then 1 more HEAL -> length=8, full=1, seg_en=8'hFF, overflow=1 and still 1 after 3 HITs (length=5).
REQ-037 SHALL verify: length=1, HIT coincident with a step -> slot0=head_in, length=0, seg_en=0, dead=1; further frame_ticks and HEALs produce no step and no change.
REQ-038 SHALL verify: move_period=0 -> step pulse after every frame_tick; then move_period changed from 5 to 2 while fcnt=3 -> step on the next tick.
REQ-039 SHALL verify: reset asserted mid-operation while length=6 and dead=0 -> outputs take REQ-033 values without waiting for a clk edge.
